// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter and its picker.
package wrr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // An index field must be at least one bit wide, even for degenerate counts.
  function automatic int idxWidth(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Requester-side and shared-bus signals of the arbiter, grouped as one bundle.
interface wrr_arbiter_if
  import wrr_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int QUOTA_WIDTH = 4
);
  localparam int IDX_W = idxWidth(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_in;
  logic [NUM_REQ*DATA_WIDTH-1:0]  wrdata_in;
  logic [NUM_REQ-1:0]             rdWrn_in;
  logic [NUM_REQ*QUOTA_WIDTH-1:0] quota;
  logic [NUM_REQ*DATA_WIDTH-1:0]  rddata_out;
  logic [ADDR_WIDTH-1:0]          address;
  logic [DATA_WIDTH-1:0]          wrdata;
  logic                           rdWrn;
  logic [DATA_WIDTH-1:0]          rddata;
  logic [IDX_W-1:0]               owner;
  logic                           preempt;

  modport master (
    output req, addr_in, wrdata_in, rdWrn_in, quota, rddata,
    input  ack, rddata_out, address, wrdata, rdWrn, owner, preempt
  );

  modport slave (
    input  req, addr_in, wrdata_in, rdWrn_in, quota, rddata,
    output ack, rddata_out, address, wrdata, rdWrn, owner, preempt
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first set request after the pointer wins.
module rr_pick
  import wrr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int w_cand;

  // Scan ptr+1, ptr+2, ... so the previous winner is considered last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = (int'(i_ptr) + i) % NUM_REQ;
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = IDX_W'(w_cand);
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: grants the shared memory bus to one requester at a time,
// revoking a grant once its cycle quota runs out while other requesters are waiting.
module wrr_arbiter
  import wrr_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int QUOTA_WIDTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  wrr_arbiter_if.slave bus
);

  localparam int IDX_W = idxWidth(NUM_REQ);

  state_e                 r_state,   w_stateNxt;
  logic [NUM_REQ-1:0]     r_ack,     w_ackNxt;
  logic [IDX_W-1:0]       r_owner,   w_ownerNxt;
  logic [IDX_W-1:0]       r_ptr,     w_ptrNxt;
  logic [QUOTA_WIDTH-1:0] r_cnt,     w_cntNxt;
  logic [QUOTA_WIDTH-1:0] r_quota,   w_quotaNxt;
  logic                   r_preempt, w_preemptNxt;

  logic [NUM_REQ-1:0]     w_pickGrant;
  logic [IDX_W-1:0]       w_pickIdx;
  logic                   w_pickValid;
  logic                   w_othersWaiting;
  logic                   w_quotaHit;
  logic [QUOTA_WIDTH-1:0] w_cntInc;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_pickGrant),
    .o_idx   (w_pickIdx),
    .o_valid (w_pickValid)
  );

  assign w_othersWaiting = |(bus.req & ~r_ack);
  assign w_quotaHit      = (r_quota != '0) && (r_cnt == (r_quota - 1'b1));
  assign w_cntInc        = (&r_cnt) ? r_cnt : (r_cnt + 1'b1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ack     <= '0;
      r_owner   <= '0;
      r_ptr     <= IDX_W'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_quota   <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_ack     <= w_ackNxt;
      r_owner   <= w_ownerNxt;
      r_ptr     <= w_ptrNxt;
      r_cnt     <= w_cntNxt;
      r_quota   <= w_quotaNxt;
      r_preempt <= w_preemptNxt;
    end
  end

  // A release by the owner takes precedence over quota expiry, so no preempt pulse then.
  always_comb begin
    w_stateNxt   = r_state;
    w_ackNxt     = r_ack;
    w_ownerNxt   = r_owner;
    w_ptrNxt     = r_ptr;
    w_cntNxt     = r_cnt;
    w_quotaNxt   = r_quota;
    w_preemptNxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pickValid) begin
          w_stateNxt = GRANT;
          w_ackNxt   = w_pickGrant;
          w_ownerNxt = w_pickIdx;
          w_ptrNxt   = w_pickIdx;
          w_cntNxt   = '0;
          w_quotaNxt = bus.quota[int'(w_pickIdx)*QUOTA_WIDTH +: QUOTA_WIDTH];
        end
      end
      GRANT: begin
        if (!bus.req[r_owner]) begin
          w_stateNxt = IDLE;
          w_ackNxt   = '0;
          w_cntNxt   = '0;
        end else if (w_quotaHit && w_othersWaiting) begin
          w_stateNxt   = IDLE;
          w_ackNxt     = '0;
          w_cntNxt     = '0;
          w_preemptNxt = 1'b1;
        end else if (w_quotaHit) begin
          w_cntNxt = '0;
        end else begin
          w_cntNxt = w_cntInc;
        end
      end
      default: begin
        w_stateNxt = IDLE;
        w_ackNxt   = '0;
      end
    endcase
  end

  // An idle bus presents a harmless read of address zero.
  always_comb begin
    bus.address = '0;
    bus.wrdata  = '0;
    bus.rdWrn   = 1'b1;
    if (|r_ack) begin
      bus.address = bus.addr_in[int'(r_owner)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.wrdata  = bus.wrdata_in[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
      bus.rdWrn   = bus.rdWrn_in[r_owner];
    end
  end

  assign bus.ack        = r_ack;
  assign bus.owner      = r_owner;
  assign bus.preempt    = r_preempt;
  assign bus.rddata_out = {NUM_REQ{bus.rddata}};

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: vector tables plus hand-built corner sequences,
// with expected grants queued at drive time and popped when the edge has happened.
module tb_wrr_arbiter;
  import wrr_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int QW   = 4;
  localparam logic [15:0] QDEF = 16'h0382;
  localparam logic [15:0] QCHG = 16'h0312;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] quota;
    logic [3:0]  ack;
    logic        pre;
    string       tag;
  } vec_t;

  typedef struct {
    logic [3:0] ack;
    logic       pre;
    bit         chkOwn;
    logic [1:0] own;
    string      tag;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   started = 1'b0;

  logic [AW-1:0] tbAddr[NREQ];
  logic [DW-1:0] tbWr[NREQ];
  logic          tbRdWrn[NREQ];
  logic [DW-1:0] tbRd;

  vec_t vecs[$];
  exp_t sb[$];
  int   errCount   = 0;
  int   checkCount = 0;

  wrr_arbiter_if #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUOTA_WIDTH(QW)
  ) bus ();

  wrr_arbiter #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUOTA_WIDTH(QW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idxOf(input logic [3:0] v);
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  task automatic driveSlots();
    for (int i = 0; i < NREQ; i++) begin
      bus.addr_in[i*AW +: AW]   = tbAddr[i];
      bus.wrdata_in[i*DW +: DW] = tbWr[i];
      bus.rdWrn_in[i]           = tbRdWrn[i];
    end
    tbRd       = DW'($urandom);
    bus.rddata = tbRd;
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWr;
    logic          expRdWrn;
    if (sb.size() == 0) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    expAddr  = (e.ack != 4'd0) ? tbAddr[e.own]  : '0;
    expWr    = (e.ack != 4'd0) ? tbWr[e.own]    : '0;
    expRdWrn = (e.ack != 4'd0) ? tbRdWrn[e.own] : 1'b1;
    checkVal({e.tag, "_ack"},     32'(bus.ack),     32'(e.ack));
    checkVal({e.tag, "_preempt"}, 32'(bus.preempt), 32'(e.pre));
    if (e.chkOwn) checkVal({e.tag, "_owner"}, 32'(bus.owner), 32'(e.own));
    checkVal({e.tag, "_address"}, 32'(bus.address), 32'(expAddr));
    checkVal({e.tag, "_wrdata"},  32'(bus.wrdata),  32'(expWr));
    checkVal({e.tag, "_rdWrn"},   32'(bus.rdWrn),   32'(expRdWrn));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] q,
                               input logic [3:0] a, input logic p, input string tag);
    bus.req   = r;
    bus.quota = q;
    driveSlots();
    sb.push_back('{a, p, (a != 4'd0), idxOf(a), tag});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      driveSlots();
      sb.push_back('{4'd0, 1'b0, 1'b1, 2'd0, "reset"});
      @(posedge clk);
      #1;
      checkOutput();
    end
    reset = 1'b1;
  endtask

  task automatic addVec(input int n, input logic [3:0] r, input logic [15:0] q,
                        input logic [3:0] a, input logic p, input string tag);
    repeat (n) vecs.push_back('{r, q, a, p, tag});
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].quota, vecs[i].ack, vecs[i].pre, vecs[i].tag);
    end
    vecs.delete();
  endtask

  // Grant exclusivity and the read-data broadcast must hold on every cycle.
  always @(negedge clk) begin
    if (started) begin
      checkVal("onehot0_ack", 32'($onehot0(bus.ack)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        checkVal("rddata_slot", 32'(bus.rddata_out[i*DW +: DW]), 32'(tbRd));
      end
    end
  end

  initial begin
    #200000;
    errCount++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req   = '0;
    bus.quota = QDEF;
    for (int i = 0; i < NREQ; i++) begin
      tbAddr[i]  = AW'(32'h110 * (i + 1));
      tbWr[i]    = DW'(32'h11 * (i + 1));
      tbRdWrn[i] = (i % 2 == 0) ? 1'b1 : 1'b0;
    end
    driveSlots();
    started = 1'b1;
    $display("[TB] start");

    doReset(2);

    // Lone requester 0: granted one edge later, quota wraps without preemption.
    addVec(1,  4'b0001, QDEF, 4'b0001, 1'b0, "r0_grant");
    addVec(10, 4'b0001, QDEF, 4'b0001, 1'b0, "r0_hold");
    addVec(1,  4'b0000, QDEF, 4'b0000, 1'b0, "r0_release");
    addVec(1,  4'b0000, QDEF, 4'b0000, 1'b0, "idle");
    runTable();

    // All four requesting: order 0,1,2,3,0 with quota 2,8,3,unlimited.
    doReset(1);
    addVec(2, 4'b1111, QDEF, 4'b0001, 1'b0, "all_r0");
    addVec(1, 4'b1111, QDEF, 4'b0000, 1'b1, "all_pre0");
    addVec(1, 4'b1111, QDEF, 4'b0010, 1'b0, "all_r1");
    addVec(7, 4'b1111, QCHG, 4'b0010, 1'b0, "all_r1_qchg");
    addVec(1, 4'b1111, QDEF, 4'b0000, 1'b1, "all_pre1");
    addVec(3, 4'b1111, QDEF, 4'b0100, 1'b0, "all_r2");
    addVec(1, 4'b1111, QDEF, 4'b0000, 1'b1, "all_pre2");
    addVec(6, 4'b1111, QDEF, 4'b1000, 1'b0, "all_r3");
    addVec(1, 4'b0111, QDEF, 4'b0000, 1'b0, "all_r3_release");
    addVec(1, 4'b0111, QDEF, 4'b0001, 1'b0, "all_r0_again");
    addVec(2, 4'b0000, QDEF, 4'b0000, 1'b0, "all_idle");
    runTable();

    // Owner 1 releases on the very edge its quota expires while 2 waits.
    doReset(1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0010, QDEF, 4'b0010, 1'b0, "rel_r1");
    for (int i = 0; i < 4; i++) applyStimulus(4'b0110, QDEF, 4'b0010, 1'b0, "rel_r1_wait2");
    applyStimulus(4'b0100, QDEF, 4'b0000, 1'b0, "rel_drop");
    applyStimulus(4'b0100, QDEF, 4'b0100, 1'b0, "rel_r2_grant");

    // Owner 2 alone for 12 cycles; its bus fields change mid-ownership and pass straight through.
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        tbAddr[2]  = 12'hABC;
        tbWr[2]    = 8'h5A;
        tbRdWrn[2] = 1'b0;
      end
      applyStimulus(4'b0100, QDEF, 4'b0100, 1'b0, "solo_r2");
    end
    applyStimulus(4'b0000, QDEF, 4'b0000, 1'b0, "solo_release");

    // Reset asserted while requester 3 owns; pointer restarts so 1 beats 3 afterwards.
    doReset(1);
    applyStimulus(4'b1000, QDEF, 4'b1000, 1'b0, "mid_r3");
    applyStimulus(4'b1000, QDEF, 4'b1000, 1'b0, "mid_r3_hold");
    doReset(2);
    applyStimulus(4'b1010, QDEF, 4'b0010, 1'b0, "post_r1_first");
    applyStimulus(4'b1010, QDEF, 4'b0010, 1'b0, "post_r1_hold");
    applyStimulus(4'b0000, QDEF, 4'b0000, 1'b0, "post_release");

    @(negedge clk);
    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
